// File: rtl/cpu_pkg.sv
// Shared types for the Mini SRC control sequencer: opcodes, step states, strobe bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int OPW     = 5;
    localparam int T_STEPS = 8;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef struct packed {
        logic pcout;
        logic pcin;
        logic incpc;
        logic marin;
        logic mdrin;
        logic mdrout;
        logic read;
        logic write;
        logic irin;
        logic yin;
        logic zlowin;
        logic zhighin;
        logic zlowout;
        logic zhighout;
        logic cout;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic baout;
        logic conin;
    } strobe_t;

    // Final execute step of each instruction; the sequencer returns to T0 after it.
    function automatic state_t last_state(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                        last_state = ST_T7;
            OP_BR:                               last_state = ST_T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_ADDI, OP_ANDI, OP_ORI:     last_state = ST_T5;
            default:                             last_state = ST_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR opcode/condition/stop in, strobes out.
// Latency: n/a (wires only).
// Backpressure: none; strobes are a per-cycle decode.
interface control_unit_if #(parameter int OPW = 5) ();

    logic [OPW-1:0] opcode;
    logic           con_ff;
    logic           stop;
    logic           run;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
    logic ZLowIn, ZHighIn, ZLowout, ZHighout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CONin;

    modport master (
        input  opcode, con_ff, stop,
        output run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
               ZLowIn, ZHighIn, ZLowout, ZHighout, Cout,
               Gra, Grb, Grc, Rin, Rout, BAout, CONin
    );

    modport slave (
        output opcode, con_ff, stop,
        input  run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
               ZLowIn, ZHighIn, ZLowout, ZHighout, Cout,
               Gra, Grb, Grc, Rin, Rout, BAout, CONin
    );

endinterface

// File: rtl/step_decoder.sv
// Pure combinational decode of sequencer state + opcode + con_ff into datapath strobes.
// Latency: 0 cycles.
// Backpressure: none.
module step_decoder
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           con_ff,
    output strobe_t        stb,
    output logic           run
);

    always_comb begin
        stb = '0;
        run = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                stb.pcout  = 1'b1;
                stb.marin  = 1'b1;
                stb.incpc  = 1'b1;
                stb.zlowin = 1'b1;
            end
            ST_T1: begin
                stb.zlowout = 1'b1;
                stb.pcin    = 1'b1;
                stb.read    = 1'b1;
                stb.mdrin   = 1'b1;
            end
            ST_T2: begin
                stb.mdrout = 1'b1;
                stb.irin   = 1'b1;
            end
            ST_T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        stb.grb   = 1'b1;
                        stb.baout = 1'b1;
                        stb.yin   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        stb.grb  = 1'b1;
                        stb.rout = 1'b1;
                        stb.yin  = 1'b1;
                    end
                    OP_BR: begin
                        stb.gra   = 1'b1;
                        stb.rout  = 1'b1;
                        stb.conin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: begin
                        stb.cout   = 1'b1;
                        stb.zlowin = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        stb.grc     = 1'b1;
                        stb.rout    = 1'b1;
                        stb.zlowin  = 1'b1;
                        stb.zhighin = 1'b1;
                    end
                    OP_BR: begin
                        stb.pcout = 1'b1;
                        stb.yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin
                        stb.zlowout = 1'b1;
                        stb.marin   = 1'b1;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        stb.zlowout = 1'b1;
                        stb.gra     = 1'b1;
                        stb.rin     = 1'b1;
                    end
                    OP_BR: begin
                        stb.cout   = 1'b1;
                        stb.zlowin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (opcode)
                    OP_LD: begin
                        stb.read  = 1'b1;
                        stb.mdrin = 1'b1;
                    end
                    // Store loads MDR from the register file, so memory read stays off.
                    OP_ST: begin
                        stb.gra   = 1'b1;
                        stb.rout  = 1'b1;
                        stb.mdrin = 1'b1;
                    end
                    OP_BR: begin
                        stb.zlowout = con_ff;
                        stb.pcin    = con_ff;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OP_LD: begin
                        stb.mdrout = 1'b1;
                        stb.gra    = 1'b1;
                        stb.rin    = 1'b1;
                    end
                    OP_ST:   stb.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Mini SRC: fetch T0-T2, execute T3-T7, HALT on halt/stop.
// Latency: strobes are a same-cycle decode of the state register; one step per clk.
// Backpressure: none; stop is honoured only at an instruction boundary.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master cu
);

    state_t         state;
    state_t         state_nxt;
    strobe_t        stb;
    logic           run;
    logic [OPW-1:0] op;

    assign op = cu.opcode;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= ST_RST;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:  state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_HALT: state_nxt = ST_HALT;
            default: begin
                // T7 always ends an instruction, so a bad opcode cannot walk past it.
                if (state == ST_T3 && op == OP_HALT)
                    state_nxt = ST_HALT;
                else if (state == last_state(op) || state == ST_T7)
                    state_nxt = cu.stop ? ST_HALT : ST_T0;
                else
                    state_nxt = state_t'(state + 4'd1);
            end
        endcase
    end

    step_decoder #(.OPW(OPW)) u_step_decoder (
        .state  (state),
        .opcode (op),
        .con_ff (cu.con_ff),
        .stb    (stb),
        .run    (run)
    );

    assign cu.run      = run;
    assign cu.PCout    = stb.pcout;
    assign cu.PCin     = stb.pcin;
    assign cu.IncPC    = stb.incpc;
    assign cu.MARin    = stb.marin;
    assign cu.MDRin    = stb.mdrin;
    assign cu.MDRout   = stb.mdrout;
    assign cu.Read     = stb.read;
    assign cu.Write    = stb.write;
    assign cu.IRin     = stb.irin;
    assign cu.Yin      = stb.yin;
    assign cu.ZLowIn   = stb.zlowin;
    assign cu.ZHighIn  = stb.zhighin;
    assign cu.ZLowout  = stb.zlowout;
    assign cu.ZHighout = stb.zhighout;
    assign cu.Cout     = stb.cout;
    assign cu.Gra      = stb.gra;
    assign cu.Grb      = stb.grb;
    assign cu.Grc      = stb.grc;
    assign cu.Rin      = stb.rin;
    assign cu.Rout     = stb.rout;
    assign cu.BAout    = stb.baout;
    assign cu.CONin    = stb.conin;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected strobe words queued per cycle, checked on negedge.
module tb_control_unit;

    typedef logic [22:0] vec_t;
    typedef vec_t ex_t [5];

    localparam vec_t RUN    = 23'd1 << 22;
    localparam vec_t PCOUT  = 23'd1 << 21;
    localparam vec_t PCIN   = 23'd1 << 20;
    localparam vec_t INCPC  = 23'd1 << 19;
    localparam vec_t MARIN  = 23'd1 << 18;
    localparam vec_t MDRIN  = 23'd1 << 17;
    localparam vec_t MDROUT = 23'd1 << 16;
    localparam vec_t READ   = 23'd1 << 15;
    localparam vec_t WRITE  = 23'd1 << 14;
    localparam vec_t IRIN   = 23'd1 << 13;
    localparam vec_t YIN    = 23'd1 << 12;
    localparam vec_t ZLI    = 23'd1 << 11;
    localparam vec_t ZHI    = 23'd1 << 10;
    localparam vec_t ZLO    = 23'd1 << 9;
    localparam vec_t COUT   = 23'd1 << 7;
    localparam vec_t GRA    = 23'd1 << 6;
    localparam vec_t GRB    = 23'd1 << 5;
    localparam vec_t GRC    = 23'd1 << 4;
    localparam vec_t RIN    = 23'd1 << 3;
    localparam vec_t ROUT   = 23'd1 << 2;
    localparam vec_t BAOUT  = 23'd1 << 1;
    localparam vec_t CONIN  = 23'd1 << 0;

    localparam vec_t F0 = RUN | PCOUT | MARIN | INCPC | ZLI;
    localparam vec_t F1 = RUN | ZLO | PCIN | READ | MDRIN;
    localparam vec_t F2 = RUN | MDROUT | IRIN;

    localparam vec_t MEM3 = RUN | GRB | BAOUT | YIN;
    localparam vec_t MEM4 = RUN | COUT | ZLI;
    localparam vec_t MEM5 = RUN | ZLO | MARIN;
    localparam vec_t LD6  = RUN | READ | MDRIN;
    localparam vec_t LD7  = RUN | MDROUT | GRA | RIN;
    localparam vec_t ST6  = RUN | GRA | ROUT | MDRIN;
    localparam vec_t ST7  = RUN | WRITE;
    localparam vec_t WB5  = RUN | ZLO | GRA | RIN;
    localparam vec_t ALU3 = RUN | GRB | ROUT | YIN;
    localparam vec_t ALU4 = RUN | GRC | ROUT | ZLI | ZHI;
    localparam vec_t IMM4 = RUN | COUT | ZLI;
    localparam vec_t BR3  = RUN | GRA | ROUT | CONIN;
    localparam vec_t BR4  = RUN | PCOUT | YIN;
    localparam vec_t BR5  = RUN | COUT | ZLI;
    localparam vec_t BR6T = RUN | ZLO | PCIN;
    localparam vec_t IDLE = RUN;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    control_unit_if #(.OPW(5)) cu_if ();

    control_unit #(.OPW(5)) dut (
        .clk (clk),
        .clr (clr),
        .cu  (cu_if)
    );

    vec_t got;
    assign got = {cu_if.run, cu_if.PCout, cu_if.PCin, cu_if.IncPC, cu_if.MARin, cu_if.MDRin,
                  cu_if.MDRout, cu_if.Read, cu_if.Write, cu_if.IRin, cu_if.Yin, cu_if.ZLowIn,
                  cu_if.ZHighIn, cu_if.ZLowout, cu_if.ZHighout, cu_if.Cout, cu_if.Gra,
                  cu_if.Grb, cu_if.Grc, cu_if.Rin, cu_if.Rout, cu_if.BAout, cu_if.CONin};

    vec_t  exp_q [$];
    string tag_q [$];
    int    total = 0;
    int    bad   = 0;
    vec_t  m_exp;
    string m_tag;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_tag = tag_q.pop_front();
            total++;
            if (got !== m_exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", m_tag, got, m_exp);
            end
        end
        if (cu_if.Read === 1'b1 && cu_if.Write === 1'b1) begin
            total++;
            bad++;
            $display("FAIL read_write_overlap: got Read=1 Write=1 want not both");
        end
    end

    task automatic push(input vec_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic cyc(input vec_t e, input string t);
        @(posedge clk);
        #1;
        push(e, t);
    endtask

    // Opcode/condition change only after the edge into T0, as the datapath would.
    task automatic instr(input logic [4:0] op, input logic con, input logic stp,
                         input int n, input ex_t e, input string name);
        cyc(F0, {name, " T0"});
        cu_if.opcode = op;
        cu_if.con_ff = con;
        cyc(F1, {name, " T1"});
        cyc(F2, {name, " T2"});
        for (int k = 0; k < n; k++) begin
            cyc(e[k], $sformatf("%s T%0d", name, k + 3));
        end
        cu_if.stop = stp;
    endtask

    initial begin
        cu_if.opcode = 5'b00000;
        cu_if.con_ff = 1'b0;
        cu_if.stop   = 1'b0;
        clr          = 1'b0;

        cyc(vec_t'(0), "reset0");
        cyc(vec_t'(0), "reset1");
        clr = 1'b1;

        instr(5'b00000, 1'b0, 1'b0, 5, '{MEM3, MEM4, MEM5, LD6, LD7}, "ld");
        instr(5'b00010, 1'b0, 1'b0, 5, '{MEM3, MEM4, MEM5, ST6, ST7}, "st");
        instr(5'b00011, 1'b0, 1'b0, 3, '{ALU3, ALU4, WB5, 0, 0}, "add");
        instr(5'b01011, 1'b0, 1'b0, 3, '{ALU3, IMM4, WB5, 0, 0}, "addi");
        instr(5'b10010, 1'b0, 1'b0, 4, '{BR3, BR4, BR5, IDLE, 0}, "br_nt");
        instr(5'b10010, 1'b1, 1'b0, 4, '{BR3, BR4, BR5, BR6T, 0}, "br_t");
        instr(5'b11001, 1'b0, 1'b0, 1, '{IDLE, 0, 0, 0, 0}, "nop");
        instr(5'b00111, 1'b0, 1'b0, 1, '{IDLE, 0, 0, 0, 0}, "unlisted");

        instr(5'b00001, 1'b0, 1'b1, 3, '{MEM3, MEM4, WB5, 0, 0}, "ldi_stop");
        cyc(vec_t'(0), "stop_halt");
        cu_if.stop = 1'b0;
        repeat (19) cyc(vec_t'(0), "stop_halt");
        clr = 1'b0;
        cyc(vec_t'(0), "clr_from_stop_halt");
        clr = 1'b1;

        instr(5'b11010, 1'b0, 1'b0, 1, '{IDLE, 0, 0, 0, 0}, "halt");
        repeat (20) cyc(vec_t'(0), "halt_idle");
        clr = 1'b0;
        cyc(vec_t'(0), "clr_pulse");
        clr = 1'b1;

        cyc(F0, "abort T0");
        cu_if.opcode = 5'b00010;
        cyc(F1, "abort T1");
        cyc(F2, "abort T2");
        cyc(MEM3, "abort T3");
        cyc(MEM4, "abort T4");
        @(posedge clk);
        #2;
        clr = 1'b0;
        push(vec_t'(0), "abort_async_T5");
        cyc(vec_t'(0), "abort_hold");
        cyc(vec_t'(0), "abort_hold");
        clr = 1'b1;

        instr(5'b11001, 1'b0, 1'b0, 1, '{IDLE, 0, 0, 0, 0}, "restart_nop");
        instr(5'b00100, 1'b0, 1'b0, 3, '{ALU3, ALU4, WB5, 0, 0}, "sub");
        cyc(F0, "final T0");

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
